// File: rtl/sum_pool_seq.sv
// sum_pool_seq: sums a WINDOW_SIZE x WINDOW_SIZE window of Q16.16
// sign-magnitude elements by time-multiplexing one external adder.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   start, abort          begin a window (IDLE / DONE handshake), abandon window
//   in_valid/in_data/in_ready     element input stream
//   add_a/add_b/add_c     shared adder operands (acc, in_data) and its result
//   out_valid/out_data/out_ready  window-sum output stream
//   busy, elem_count      not-IDLE flag, elements accepted in this window
module sum_pool_seq #(
    parameter int WINDOW_SIZE = 4,
    parameter int Q           = 16,
    parameter int N           = 32,
    parameter int CNT_W       = $clog2(WINDOW_SIZE*WINDOW_SIZE+1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    input  logic [N-1:0]     in_data,
    output logic             in_ready,
    output logic [N-1:0]     add_a,
    output logic [N-1:0]     add_b,
    input  logic [N-1:0]     add_c,
    output logic             out_valid,
    output logic [N-1:0]     out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic [CNT_W-1:0] elem_count
);

    localparam int TOTAL = WINDOW_SIZE * WINDOW_SIZE;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TOTAL);

    // Q only matters to the external adder; reject nonsensical builds here.
    if (WINDOW_SIZE < 1) begin : g_bad_window
        $error("sum_pool_seq: WINDOW_SIZE must be >= 1");
    end
    if (Q < 0 || Q >= N) begin : g_bad_q
        $error("sum_pool_seq: Q must lie in [0, N)");
    end

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ACCUM,
        DONE
    } state_t;

    state_t           state;
    logic [N-1:0]     acc;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc  = elem_count + CNT_W'(1);
    assign in_ready = (state == LOAD) || (state == ACCUM);
    assign busy     = (state != IDLE);
    assign add_a    = acc;
    assign add_b    = in_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            acc        <= '0;
            elem_count <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else if (abort) begin
            // Abort beats start and any handshake in the same cycle.
            state      <= IDLE;
            acc        <= '0;
            elem_count <= '0;
            out_valid  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state      <= LOAD;
                        elem_count <= '0;
                    end
                end
                LOAD: begin
                    // First element seeds acc directly; add_c is ignored.
                    if (in_valid) begin
                        acc        <= in_data;
                        elem_count <= CNT_W'(1);
                        if (TOTAL == 1) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_data  <= in_data;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        acc        <= add_c;
                        elem_count <= cnt_inc;
                        if (cnt_inc == LAST) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_data  <= add_c;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        // start on the handshake cycle skips the IDLE bubble.
                        if (start) begin
                            state      <= LOAD;
                            elem_count <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
